instr_memory_pipe: RTL and testbench

//   Parametrised instruction memory for the fetch stage: valid/ready request port, LATENCY-stage read

---
 rtl/instr_memory_pipe_pkg.sv | 36 +++
 rtl/instr_memory_pipe_if.sv | 28 ++
 rtl/instr_memory_pipe_resp_fifo.sv | 57 +++++
 rtl/instr_memory_pipe.sv | 116 +++++++++++
 tb/tb_instr_memory_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_memory_pipe_pkg.sv
// Shared types, fault codes and FSM encoding for the fetch-stage instruction memory.
package instr_memory_pipe_pkg;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  // Misalignment wins over range; the 33-bit compare keeps wrapped addresses out of the image.
  function automatic logic [1:0] addr_fault(input logic [31:0] addr, input logic [32:0] base,
                                            input logic [32:0] limit);
    logic [32:0] addr_w;
    addr_w = {1'b0, addr};
    if (addr[1:0] != 2'b00) begin
      return FAULT_MISALIGN;
    end else if ((addr_w < base) || (addr_w >= limit)) begin
      return FAULT_RANGE;
    end else begin
      return FAULT_NONE;
    end
  endfunction

endpackage

// File: rtl/instr_memory_pipe_if.sv
// Fetch-side bundle: request/response handshakes, flush, boot PC and the image preload port.
interface instr_memory_pipe_if #(
  parameter int IDX_W = 10
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_instr;
  logic [31:0]      resp_addr;
  logic [1:0]       resp_fault;
  logic [31:0]      start_addr;
  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic [31:0]      load_data;

  modport master (
    output flush, req_valid, req_addr, resp_ready, load_en, load_idx, load_data,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_fault, start_addr
  );

  modport slave (
    input  flush, req_valid, req_addr, resp_ready, load_en, load_idx, load_data,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_fault, start_addr
  );
endinterface

// File: rtl/instr_memory_pipe_resp_fifo.sv
// Response queue between the read pipeline and decode; pointers carry a wrap bit, flush empties it.
module instr_resp_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (count_r == (PTR_W + 1)'(DEPTH));
  assign pop_s     = pop && !empty;
  assign push_s    = push && (!full_s || pop_s);
  assign head_data = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Pointer and occupancy bookkeeping; flush drops every entry in one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (PTR_W + 1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (PTR_W + 1)'(1);
      count_r <= count_r + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
    end
  end

  // Entry storage, cleared on reset so the head presents zeros while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_memory_pipe.sv
// Fetch-stage instruction memory: credited request port, LATENCY-stage read pipe, response FIFO.
// The image is preloaded through the load port; word 0 becomes the boot PC.
module instr_memory_pipe
  import instr_memory_pipe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter int          FIFO_DEPTH  = 2
) (
  input logic                clock,
  input logic                reset_n,
  instr_memory_pipe_if.slave bus
);
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam int          CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] BASE_W  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_W = BASE_W + (33'(DEPTH_WORDS) << 2);

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state_r, state_nxt_s;
  logic [31:0]      start_addr_r;
  logic [CNT_W-1:0] credit_r, credit_after_pop_s;
  logic [LATENCY-1:0] valid_r;
  resp_t            pipe_r [LATENCY];
  resp_t            head_s;
  logic [1:0]       fault_s;
  logic [IDX_W-1:0] idx_s;
  logic             req_ready_s, accept_s, pop_s, fifo_empty_s;

  // Image preload; reset deliberately leaves the contents alone.
  always_ff @(posedge clock) begin
    if (bus.load_en) mem[bus.load_idx] <= bus.load_data;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_BOOT;
    else          state_r <= state_nxt_s;
  end

  // BOOT lasts exactly one clock, then RUN until the next reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Boot PC capture during the BOOT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 start_addr_r <= '0;
    else if (state_r == ST_BOOT)  start_addr_r <= mem[0];
  end

  // Address check and credit-based accept; a same-cycle pop frees its slot immediately.
  always_comb begin
    fault_s            = addr_fault(bus.req_addr, BASE_W, LIMIT_W);
    idx_s              = IDX_W'((bus.req_addr - BASE_ADDR) >> 2'd2);
    pop_s              = !fifo_empty_s && bus.resp_ready;
    credit_after_pop_s = credit_r - CNT_W'(pop_s);
    req_ready_s        = (state_r == ST_RUN) && !bus.flush &&
                         (credit_after_pop_s < CNT_W'(FIFO_DEPTH));
    accept_s           = bus.req_valid && req_ready_s;
  end

  // Outstanding count covers both pipeline and FIFO, so the FIFO can never overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       credit_r <= '0;
    else if (bus.flush) credit_r <= '0;
    else                credit_r <= credit_after_pop_s + CNT_W'(accept_s);
  end

  // Stage 0 is the synchronous memory read; later stages just carry the response along.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_r[i] <= '0;
    end else begin
      valid_r[0] <= accept_s;
      if (accept_s) begin
        pipe_r[0].addr  <= bus.req_addr;
        pipe_r[0].fault <= fault_s;
        pipe_r[0].instr <= (fault_s == FAULT_NONE) ? mem[idx_s] : NOP_INSTR;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1] && !bus.flush;
        pipe_r[i]  <= pipe_r[i-1];
      end
    end
  end

  instr_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (bus.flush),
    .push      (valid_r[LATENCY-1]),
    .push_data (pipe_r[LATENCY-1]),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (fifo_empty_s)
  );

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = !fifo_empty_s;
  assign bus.resp_instr = head_s.instr;
  assign bus.resp_addr  = head_s.addr;
  assign bus.resp_fault = head_s.fault;
  assign bus.start_addr = start_addr_r;

endmodule

// File: tb/tb_instr_memory_pipe.sv
// Directed bench: dut_a (LATENCY=1, FIFO_DEPTH=2) and dut_b (LATENCY=3, FIFO_DEPTH=4).
module tb_instr_memory_pipe;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  instr_memory_pipe_if #(.IDX_W(10)) bus_a ();
  instr_memory_pipe_if #(.IDX_W(10)) bus_b ();

  instr_memory_pipe #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(1), .FIFO_DEPTH(2))
    dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  instr_memory_pipe #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(3), .FIFO_DEPTH(4))
    dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

  always #5 clock = ~clock;

  // Image: word 0 is the boot PC, every other word is C0DE_0000 | index.
  function automatic logic [31:0] img(input int i);
    if (i == 0) return 32'h0040_0000;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.flush = 1'b0; bus_a.req_valid = 1'b0; bus_a.req_addr = 32'h0; bus_a.resp_ready = 1'b0;
    bus_a.load_en = 1'b0; bus_a.load_idx = 10'd0; bus_a.load_data = 32'h0;
    bus_b.flush = 1'b0; bus_b.req_valid = 1'b0; bus_b.req_addr = 32'h0; bus_b.resp_ready = 1'b0;
    bus_b.load_en = 1'b0; bus_b.load_idx = 10'd0; bus_b.load_data = 32'h0;
  endtask

  task automatic load_word(input int i);
    bus_a.load_en = 1'b1; bus_a.load_idx = 10'(i); bus_a.load_data = img(i);
    bus_b.load_en = 1'b1; bus_b.load_idx = 10'(i); bus_b.load_data = img(i);
    step();
    bus_a.load_en = 1'b0;
    bus_b.load_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [99:0] obs;
    idle_inputs();
    reset_n = 1'b0;
    step();
    for (int i = 0; i < 8; i++) load_word(i);
    load_word(1023);
    obs = {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr,
           bus_a.resp_fault, bus_a.start_addr};
    checks++;
    if (obs !== 100'h0) begin errors++; $display("FAIL reset_state_a got %h exp 0", obs); end
    obs = {bus_b.req_ready, bus_b.resp_valid, bus_b.resp_instr, bus_b.resp_addr,
           bus_b.resp_fault, bus_b.start_addr};
    checks++;
    if (obs !== 100'h0) begin errors++; $display("FAIL reset_state_b got %h exp 0", obs); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin errors++; $display("FAIL boot_not_ready got %b exp 0", bus_a.req_ready); end
    step();
    checks++;
    if ({bus_a.req_ready, bus_b.req_ready} !== 2'b11) begin
      errors++; $display("FAIL run_ready got %b exp 11", {bus_a.req_ready, bus_b.req_ready});
    end
    checks++;
    if (bus_a.start_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL start_addr got %h exp 00400000", bus_a.start_addr);
    end
  endtask

  task automatic test_streaming();
    bus_a.resp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus_a.req_valid = (c < 4);
      bus_a.req_addr  = BASE + 32'(4 * c);
      #1;
      if (c < 4) begin
        checks++;
        if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d got %b exp 1", c, bus_a.req_ready); end
      end
      step();
      checks++;
      if (c >= 1 && c <= 4) begin
        if ({bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr, bus_a.resp_fault} !==
            {1'b1, img(c - 1), BASE + 32'(4 * (c - 1)), 2'b00}) begin
          errors++;
          $display("FAIL stream_resp c=%0d got v=%b i=%h a=%h f=%b exp i=%h", c, bus_a.resp_valid,
                   bus_a.resp_instr, bus_a.resp_addr, bus_a.resp_fault, img(c - 1));
        end
      end else if (bus_a.resp_valid !== 1'b0) begin
        errors++; $display("FAIL stream_idle c=%0d got %b exp 0", c, bus_a.resp_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bus_a.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = BASE + 32'(16 + 4 * k);
      #1;
      checks++;
      if (bus_a.req_ready !== (k < 2)) begin
        errors++; $display("FAIL bp_ready k=%0d got %b exp %b", k, bus_a.req_ready, (k < 2));
      end
      if (k < 2) step();
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr, bus_a.req_ready} !==
          {1'b1, 32'hC0DE_0004, 32'h0010_0010, 1'b0}) begin
        errors++;
        $display("FAIL bp_head_stable c=%0d got v=%b i=%h a=%h r=%b exp i=c0de0004", c,
                 bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr, bus_a.req_ready);
      end
    end
    bus_a.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_on_pop got %b exp 1", bus_a.req_ready); end
    step();
    bus_a.req_valid = 1'b0;
    for (int k = 5; k < 8; k++) begin
      checks++;
      if (k < 7) begin
        if ({bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr} !== {1'b1, img(k), BASE + 32'(4 * k)}) begin
          errors++; $display("FAIL bp_order k=%0d got v=%b i=%h exp %h", k, bus_a.resp_valid, bus_a.resp_instr, img(k));
        end
      end else if (bus_a.resp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_drain got %b exp 0", bus_a.resp_valid);
      end
      step();
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs  [4] = '{32'h0010_0002, 32'h0010_1000, 32'h000F_FFFC, 32'h0010_0FFC};
    logic [1:0]  faults [4] = '{2'b01, 2'b10, 2'b10, 2'b00};
    logic [31:0] instrs [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hC0DE_03FF};
    bus_a.resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_a.req_valid = (c < 4);
      bus_a.req_addr  = (c < 4) ? addrs[c] : 32'h0;
      step();
      if (c >= 1) begin
        checks++;
        if ({bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr, bus_a.resp_fault} !==
            {1'b1, instrs[c - 1], addrs[c - 1], faults[c - 1]}) begin
          errors++;
          $display("FAIL fault_resp addr=%h got v=%b i=%h f=%b exp i=%h f=%b", addrs[c - 1],
                   bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_fault, instrs[c - 1], faults[c - 1]);
        end
      end
    end
    step();
  endtask

  task automatic test_flush();
    bus_b.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_b.req_valid = 1'b1;
      bus_b.req_addr  = BASE + 32'(4 * k);
      step();
    end
    bus_b.req_valid = 1'b0;
    step();
    checks++;
    if ({bus_b.resp_valid, bus_b.resp_instr} !== {1'b1, 32'h0040_0000}) begin
      errors++; $display("FAIL flush_pre_head got v=%b i=%h exp 1/00400000", bus_b.resp_valid, bus_b.resp_instr);
    end
    bus_b.flush     = 1'b1;
    bus_b.req_valid = 1'b1;
    bus_b.req_addr  = BASE + 32'h14;
    #1;
    checks++;
    if (bus_b.req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", bus_b.req_ready); end
    step();
    bus_b.flush     = 1'b0;
    bus_b.req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus_b.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_stale c=%0d got %b exp 0", c, bus_b.resp_valid); end
      step();
    end
    bus_b.resp_ready = 1'b1;
    bus_b.req_valid  = 1'b1;
    bus_b.req_addr   = BASE + 32'h1C;
    #1;
    checks++;
    if (bus_b.req_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b exp 1", bus_b.req_ready); end
    step();
    bus_b.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (c < 3) begin
        if (bus_b.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_lat c=%0d got %b exp 0", c, bus_b.resp_valid); end
      end else if ({bus_b.resp_valid, bus_b.resp_instr, bus_b.resp_addr} !== {1'b1, 32'hC0DE_0007, 32'h0010_001C}) begin
        errors++; $display("FAIL flush_after_resp got v=%b i=%h a=%h exp c0de0007", bus_b.resp_valid, bus_b.resp_instr, bus_b.resp_addr);
      end
    end
    step();
  endtask

  task automatic test_midop_reset();
    logic [99:0] obs;
    bus_a.resp_ready = 1'b0;
    for (int k = 2; k < 4; k++) begin
      bus_a.req_valid = 1'b1;
      bus_a.req_addr  = BASE + 32'(4 * k);
      step();
    end
    bus_a.req_valid = 1'b0;
    step();
    checks++;
    if ({bus_a.resp_valid, bus_a.resp_instr, bus_a.req_ready} !== {1'b1, 32'hC0DE_0002, 1'b0}) begin
      errors++; $display("FAIL midop_full got v=%b i=%h r=%b exp 1/c0de0002/0", bus_a.resp_valid, bus_a.resp_instr, bus_a.req_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    obs = {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_instr, bus_a.resp_addr,
           bus_a.resp_fault, bus_a.start_addr};
    checks++;
    if (obs !== 100'h0) begin errors++; $display("FAIL midop_async_reset got %h exp 0", obs); end
    step();
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin errors++; $display("FAIL reboot_not_ready got %b exp 0", bus_a.req_ready); end
    step();
    checks++;
    if ({bus_a.req_ready, bus_a.start_addr} !== {1'b1, 32'h0040_0000}) begin
      errors++; $display("FAIL reboot got r=%b s=%h exp 1/00400000", bus_a.req_ready, bus_a.start_addr);
    end
    bus_a.resp_ready = 1'b1;
    bus_a.req_valid  = 1'b1;
    bus_a.req_addr   = BASE + 32'h0C;
    step();
    bus_a.req_valid = 1'b0;
    step();
    checks++;
    if ({bus_a.resp_valid, bus_a.resp_instr} !== {1'b1, 32'hC0DE_0003}) begin
      errors++; $display("FAIL mem_kept got v=%b i=%h exp 1/c0de0003", bus_a.resp_valid, bus_a.resp_instr);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_faults();
    test_flush();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
